// File: rtl/io_board_pkg.sv
// Shared io_board definitions: scanner state encodings, default scan timing
// and the active-low seven-segment glyph table (bit 7 = dp, bits 6:0 = g..a).
package io_board_pkg;

   localparam int DEFAULT_DIGIT_CYCLES = 16384;
   localparam int DEFAULT_BLANK_CYCLES = 64;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // Entry n is the glyph for nibble n; the dp bit is left dark (1) in every entry.
   localparam logic [15:0][7:0] GLYPH_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   localparam logic [3:0] SEL_OFF = 4'hF;
   localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder (segments g..a).
module seg7_decode
   import io_board_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup; the dp bit of the glyph is handled by the caller.
   assign seg = GLYPH_TABLE[nibble][6:0];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner. Each digit slot starts with a
// blanked guard interval (ghosting suppression) followed by the driven phase.
// New display contents are accepted into a pending register and only become
// visible at a frame boundary, so a frame never shows a torn value.
//
// Load handshake: a load transfers on any rising edge where load_valid and
// load_ready are both high; value_in, dp_in and blank_in are sampled on that
// edge only. load_ready is low while a load is pending, i.e. from the cycle
// after acceptance up to and including the frame boundary that commits it.
module seven_seg_scanner
   import io_board_pkg::*;
#(
   parameter int DIGIT_CYCLES = DEFAULT_DIGIT_CYCLES,
   parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        load_valid,
   output logic        load_ready,
   output logic [3:0]  io_sel,
   output logic [7:0]  io_seg,
   output logic        frame_done,
   output logic        state_dbg
);

   localparam int CNT_W = $clog2(DIGIT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_t      state;
   logic [CNT_W-1:0] slot_cnt;
   logic [1:0]       idx;

   logic [15:0]      disp_value;
   logic [3:0]       disp_dp;
   logic [3:0]       disp_blank;

   logic             pend_full;
   logic [15:0]      pend_value;
   logic [3:0]       pend_dp;
   logic [3:0]       pend_blank;

   logic [3:0]       cur_nibble;
   logic [6:0]       cur_glyph;
   logic             frame_end;
   logic             load_fire;

   assign load_ready = !pend_full;
   assign load_fire  = load_valid && load_ready;
   assign frame_end  = (state == DRIVE) && (idx == 2'd3) && (slot_cnt == LAST_CNT);
   assign frame_done = frame_end;
   assign state_dbg  = state;
   assign cur_nibble = disp_value[{idx, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble (cur_nibble),
      .seg    (cur_glyph)
   );

   // Slot timing FSM; outputs are loaded on the edge that enters each phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BLANK;
         slot_cnt <= '0;
         idx      <= '0;
         io_sel   <= SEL_OFF;
         io_seg   <= SEG_OFF;
      end else begin
         slot_cnt <= (slot_cnt == LAST_CNT) ? '0 : slot_cnt + 1'b1;
         case (state)
            BLANK: begin
               if (slot_cnt == BLANK_LAST) begin
                  state <= DRIVE;
                  if (!disp_blank[idx]) begin
                     io_sel <= ~(4'b0001 << idx);
                     io_seg <= {~disp_dp[idx], cur_glyph};
                  end
               end
            end
            DRIVE: begin
               if (slot_cnt == LAST_CNT) begin
                  state  <= BLANK;
                  idx    <= idx + 1'b1;
                  io_sel <= SEL_OFF;
                  io_seg <= SEG_OFF;
               end
            end
            default: state <= BLANK;
         endcase
      end
   end

   // Capture accepted loads into pending; promote pending to the display at the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_value <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
         pend_full  <= 1'b0;
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
      end else if (frame_end && pend_full) begin
         disp_value <= pend_value;
         disp_dp    <= pend_dp;
         disp_blank <= pend_blank;
         pend_full  <= 1'b0;
      end else if (load_fire) begin
         pend_value <= value_in;
         pend_dp    <= dp_in;
         pend_blank <= blank_in;
         pend_full  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with an 8-cycle slot and 2-cycle blank guard.
module tb_seven_seg_scanner;

   localparam int DIGIT_CYCLES = 8;
   localparam int BLANK_CYCLES = 2;
   localparam int FRAME        = 4 * DIGIT_CYCLES;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [3:0]  io_sel;
   logic [7:0]  io_seg;
   logic        frame_done;
   logic        state_dbg;

   int checks = 0;
   int errors = 0;
   int cyc;

   // {load_ready, frame_done, io_sel, io_seg} expected for each cycle of a frame
   logic [13:0] exp_q[$];

   logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // displayed contents as the bench believes them to be
   logic [15:0] m_val = '0;
   logic [3:0]  m_dp  = '0;
   logic [3:0]  m_blk = '0;

   seven_seg_scanner #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .io_sel     (io_sel),
      .io_seg     (io_seg),
      .frame_done (frame_done),
      .state_dbg  (state_dbg)
   );

   // clock and cycle-since-reset counter
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout t=%0t", $time);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic logic [7:0] exp_drive_seg(input logic [15:0] val, input logic [3:0] dp, input int s);
      logic [3:0] nib;
      logic [7:0] g;
      nib = 4'(val >> (4 * s));
      g = glyph_tab[nib];
      return {~dp[s], g[6:0]};
   endfunction

   task automatic push_frame(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] blk,
                             input int load_at);
      for (int p = 0; p < FRAME; p++) begin
         int s;
         logic [3:0] sel;
         logic [7:0] seg;
         logic rdy, fd;
         s = p / DIGIT_CYCLES;
         if ((p % DIGIT_CYCLES) < BLANK_CYCLES || blk[s]) begin
            sel = 4'hF;
            seg = 8'hFF;
         end else begin
            sel = 4'hF;
            sel[s] = 1'b0;
            seg = exp_drive_seg(val, dp, s);
         end
         rdy = (load_at < 0) || (p <= load_at);
         fd  = (p == FRAME - 1);
         exp_q.push_back({rdy, fd, sel, seg});
      end
   endtask

   task automatic wait_phase(input int ph);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((cyc % FRAME) != ph && guard < 2 * FRAME) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if ((cyc % FRAME) != ph) begin
         $display("FAIL align got=%0d exp=%0d", cyc % FRAME, ph);
         errors++;
      end
   endtask

   // Check one whole frame; optionally offer a load at cycle load_at of the frame.
   task automatic run_frame(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] blk,
                            input int load_at, input logic [15:0] lval, input logic [3:0] ldp,
                            input logic [3:0] lblk, input bit hold, input logic [15:0] hval);
      logic [13:0] e;
      push_frame(val, dp, blk, load_at);
      wait_phase(0);
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (io_sel !== e[11:8]) begin
            $display("FAIL io_sel cyc=%0d got=%h exp=%h", i, io_sel, e[11:8]);
            errors++;
         end
         checks++;
         if (io_seg !== e[7:0]) begin
            $display("FAIL io_seg cyc=%0d got=%h exp=%h", i, io_seg, e[7:0]);
            errors++;
         end
         checks++;
         if (frame_done !== e[12]) begin
            $display("FAIL frame_done cyc=%0d got=%b exp=%b", i, frame_done, e[12]);
            errors++;
         end
         checks++;
         if (load_ready !== e[13]) begin
            $display("FAIL load_ready cyc=%0d got=%b exp=%b", i, load_ready, e[13]);
            errors++;
         end
         if (load_at >= 0 && i == load_at) begin
            load_valid = 1'b1;
            value_in   = lval;
            dp_in      = ldp;
            blank_in   = lblk;
         end else if (load_at >= 0 && i == load_at + 1) begin
            if (hold) begin
               value_in = hval;
            end else begin
               load_valid = 1'b0;
               value_in   = 16'($urandom);
               dp_in      = 4'($urandom_range(0, 15));
               blank_in   = 4'($urandom_range(0, 15));
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      value_in = 16'($urandom);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (io_sel !== 4'hF || io_seg !== 8'hFF) begin
         $display("FAIL reset_outputs got=%h/%h exp=f/ff", io_sel, io_seg);
         errors++;
      end
      checks++;
      if (load_ready !== 1'b1 || frame_done !== 1'b0 || state_dbg !== 1'b0) begin
         $display("FAIL reset_flags got=%b%b%b exp=100", load_ready, frame_done, state_dbg);
         errors++;
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      m_val = '0; m_dp = '0; m_blk = '0;
      run_frame(m_val, m_dp, m_blk, -1, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_load();
      run_frame(m_val, m_dp, m_blk, 5, 16'h1234, 4'b0010, 4'b0000, 1'b0, '0);
      m_val = 16'h1234; m_dp = 4'b0010; m_blk = '0;
      run_frame(m_val, m_dp, m_blk, -1, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_back_to_back();
      run_frame(m_val, m_dp, m_blk, 3, 16'hAAAA, 4'b0000, 4'b0000, 1'b1, 16'hBBBB);
      m_val = 16'hAAAA; m_dp = '0; m_blk = '0;
      run_frame(m_val, m_dp, m_blk, 0, 16'hBBBB, 4'b0000, 4'b0000, 1'b0, '0);
      m_val = 16'hBBBB;
      run_frame(m_val, m_dp, m_blk, -1, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_blank();
      run_frame(m_val, m_dp, m_blk, 4, 16'h8888, 4'b0000, 4'b1000, 1'b0, '0);
      m_val = 16'h8888; m_dp = '0; m_blk = 4'b1000;
      run_frame(m_val, m_dp, m_blk, -1, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_reset_mid_drive();
      wait_phase(3);
      load_valid = 1'b1;
      value_in   = 16'h5A5A;
      dp_in      = 4'b1111;
      blank_in   = 4'b0000;
      @(negedge clk);
      load_valid = 1'b0;
      checks++;
      if (load_ready !== 1'b0) begin
         $display("FAIL pending_ready got=%b exp=0", load_ready);
         errors++;
      end
      wait_phase(20);
      checks++;
      if (io_sel !== 4'b1011 || io_seg !== exp_drive_seg(m_val, m_dp, 2)) begin
         $display("FAIL drive_digit2 got=%h/%h exp=b/%h", io_sel, io_seg, exp_drive_seg(m_val, m_dp, 2));
         errors++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (io_sel !== 4'hF || io_seg !== 8'hFF) begin
         $display("FAIL async_reset got=%h/%h exp=f/ff", io_sel, io_seg);
         errors++;
      end
      checks++;
      if (load_ready !== 1'b1 || frame_done !== 1'b0) begin
         $display("FAIL async_reset_flags got=%b%b exp=10", load_ready, frame_done);
         errors++;
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      m_val = '0; m_dp = '0; m_blk = '0;
      run_frame(m_val, m_dp, m_blk, -1, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_glyphs();
      logic [15:0] vals [4];
      vals = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
      for (int k = 0; k < 4; k++) begin
         logic [3:0] d;
         int at;
         d  = 4'($urandom_range(0, 15));
         at = $urandom_range(1, 30);
         run_frame(m_val, m_dp, m_blk, at, vals[k], d, 4'b0000, 1'b0, '0);
         m_val = vals[k]; m_dp = d; m_blk = '0;
      end
      run_frame(m_val, m_dp, m_blk, -1, '0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_blank();
      test_reset_mid_drive();
      test_glyphs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
